// File: rtl/mp_pkg.sv
// ============================================================================
// Module      : mp_pkg
// Description : Shared widths, FSM encoding and mpadder mode constants
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mp_pkg;
    localparam int W       = 1027;
    localparam int W1      = W + 1;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_ISSUE1 = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT1  = 3'd2;
    localparam logic [STATE_W-1:0] S_ISSUE2 = 3'd3;
    localparam logic [STATE_W-1:0] S_WAIT2  = 3'd4;
    localparam logic [STATE_W-1:0] S_FIN    = 3'd5;

    localparam logic MP_ADD = 1'b0;
    localparam logic MP_SUB = 1'b1;
endpackage

`default_nettype wire

// File: rtl/mod_addsub_ctrl_if.sv
// ============================================================================
// Module      : mod_addsub_ctrl_if
// Description : start/done handshake between the sequencer and one mpadder
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mod_addsub_ctrl_if
    import mp_pkg::*;
();
    logic          add_start;
    logic          add_subtract;
    logic [W-1:0]  add_in_a;
    logic [W-1:0]  add_in_b;
    logic [W1-1:0] add_result;
    logic          add_done;

    modport master (
        output add_start, add_subtract, add_in_a, add_in_b,
        input  add_result, add_done
    );

    modport slave (
        input  add_start, add_subtract, add_in_a, add_in_b,
        output add_result, add_done
    );
endinterface

`default_nettype wire

// File: rtl/mod_addsub_ctrl.sv
// ============================================================================
// Module      : mod_addsub_ctrl
// Description : (a+b) mod M / (a-b) mod M sequencer driving a shared mpadder.
//               Define MODADDSUB_CONST_TIME_EN to always run two adder passes.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_addsub_ctrl
    import mp_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              subtract,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [W-1:0]      in_m,
    output logic [W-1:0]      result,
    output logic              done,
    output logic              busy,
    mod_addsub_ctrl_if.master adder
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               r_op;
    logic [W-1:0]       r_m;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic               r_op_sub;
    logic [W:0]         r_r1;
    logic [W-1:0]       r_result;
    logic [W-1:0]       w_sel;
    logic               w_skip2;

    // A subtraction without borrow is already reduced; constant-time builds never skip.
`ifdef MODADDSUB_CONST_TIME_EN
    assign w_skip2 = 1'b0;
`else
    assign w_skip2 = (r_op == MP_SUB) && !adder.add_result[W];
`endif

    // add_result holds r2 while in WAIT2
    always_comb begin
        w_sel = r_r1[W-1:0];
        if (r_op == MP_ADD) begin
            if (!adder.add_result[W])
                w_sel = adder.add_result[W-1:0];
        end else if (r_r1[W]) begin
            w_sel = adder.add_result[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_ISSUE1;
            S_ISSUE1: w_state_next = S_WAIT1;
            S_WAIT1:  if (adder.add_done) w_state_next = w_skip2 ? S_FIN : S_ISSUE2;
            S_ISSUE2: w_state_next = S_WAIT2;
            S_WAIT2:  if (adder.add_done) w_state_next = S_FIN;
            S_FIN:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        adder.add_start    = (r_state == S_ISSUE1) || (r_state == S_ISSUE2);
        adder.add_subtract = r_op_sub;
        adder.add_in_a     = r_op_a;
        adder.add_in_b     = r_op_b;
        done               = (r_state == S_FIN);
        busy               = (r_state != S_IDLE);
        result             = r_result;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op     <= MP_ADD;
            r_m      <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_sub <= MP_ADD;
            r_r1     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= subtract;
                        r_m      <= in_m;
                        r_op_a   <= in_a;
                        r_op_b   <= in_b;
                        r_op_sub <= subtract;
                    end
                end
                S_WAIT1: begin
                    if (adder.add_done) begin
                        r_r1     <= adder.add_result;
                        r_op_a   <= adder.add_result[W-1:0];
                        r_op_b   <= r_m;
                        r_op_sub <= (r_op == MP_ADD) ? MP_SUB : MP_ADD;
                        if (w_skip2)
                            r_result <= adder.add_result[W-1:0];
                    end
                end
                S_WAIT2: begin
                    if (adder.add_done)
                        r_result <= w_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
